// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for mem_port_arbiter.
// State/grant enums, full byte-enable and forced-completion read value.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_e;

  localparam logic [3:0]  BE_FULL   = 4'hF;
  localparam logic [31:0] RDATA_ERR = 32'h0;

endpackage

// File: rtl/arb_timeout.sv
// arb_timeout: busy-cycle counter for the memory port arbiter.
// Ports: clk, rst (sync, active-high), clr, en, expired.
// expired is high in the TIMEOUT-th consecutive enabled cycle,
// so the access completes after exactly TIMEOUT stalled cycles.
// TIMEOUT = 0 disables expiry.
module arb_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TCW     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TCW-1:0] LAST =
    TCW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TCW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port
// between instruction fetch (i_*) and data access (d_*).
// Ports: clk, rst (sync, active-high); i_req/i_addr -> i_ack,
// i_rdata, i_stall; d_req/d_we/d_be/d_addr/d_wdata -> d_ack,
// d_rdata, d_stall; mem_* registered request, mem_ready/
// mem_rdata from memory; err sticky timeout flag.
// Option: MEM_ARB_IBUF_EN adds a one-entry fetch buffer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TCW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  state_e state_q, state_d;
  grant_e last_q, last_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;

  logic          grant_i, grant_d;
  logic          busy, done;
  logic          to_en, to_exp;
  logic [DW-1:0] fill;
  logic          ibuf_hit;
  logic [DW-1:0] ibuf_rdata;

  assign busy  = (state_q == IBUSY) || (state_q == DBUSY);
  assign to_en = busy && !mem_ready;
  assign done  = busy && (mem_ready || to_exp);
  assign fill  = mem_ready ? mem_rdata : DW'(RDATA_ERR);

  arb_timeout #(
    .TIMEOUT (TIMEOUT),
    .TCW     (TCW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_i | grant_d),
    .en      (to_en),
    .expired (to_exp)
  );

`ifdef MEM_ARB_IBUF_EN
  logic          ibuf_v_q, ibuf_v_d;
  logic [AW-1:0] ibuf_tag_q, ibuf_tag_d;
  logic [DW-1:0] ibuf_data_q, ibuf_data_d;

  // A pending data request always goes first to memory.
  assign ibuf_hit = i_req && !d_req && ibuf_v_q &&
                    (ibuf_tag_q == i_addr);
  assign ibuf_rdata = ibuf_data_q;

  always_comb begin
    ibuf_v_d    = ibuf_v_q;
    ibuf_tag_d  = ibuf_tag_q;
    ibuf_data_d = ibuf_data_q;
    // Only real memory data refills; a timed-out fetch does not.
    if (done && (state_q == IBUSY) && mem_ready) begin
      ibuf_v_d    = 1'b1;
      ibuf_tag_d  = mem_addr_q;
      ibuf_data_d = mem_rdata;
    end
    if (grant_d && d_we && (d_addr == ibuf_tag_q)) begin
      ibuf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_v_q    <= 1'b0;
      ibuf_tag_q  <= '0;
      ibuf_data_q <= '0;
    end else begin
      ibuf_v_q    <= ibuf_v_d;
      ibuf_tag_q  <= ibuf_tag_d;
      ibuf_data_q <= ibuf_data_d;
    end
  end
`else
  assign ibuf_hit   = 1'b0;
  assign ibuf_rdata = '0;
`endif

  // Grant decision; a conflict goes to the side not served last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        (i_req && d_req): begin
          if (last_q == INSTR) grant_d = 1'b1;
          else                 grant_i = 1'b1;
        end
        (d_req && !i_req): grant_d = 1'b1;
        (i_req && !d_req && !ibuf_hit): grant_i = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DBUSY;
          last_d  = DATA;
        end else if (grant_i) begin
          state_d = IBUSY;
          last_d  = INSTR;
        end
      end
      IBUSY, DBUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_be_d    = d_be;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end
    if (grant_i) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_be_d   = BE_FULL;
      mem_addr_d = i_addr;
    end
    if (ibuf_hit) begin
      i_ack_d   = 1'b1;
      i_rdata_d = ibuf_rdata;
    end
    if (done) begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (!mem_ready) err_d = 1'b1;
      if (state_q == IBUSY) begin
        i_ack_d   = 1'b1;
        i_rdata_d = fill;
      end else begin
        d_ack_d   = 1'b1;
        d_rdata_d = fill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= INSTR;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign i_stall   = i_req & ~i_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Vector table plus hand sequences; acks checked via scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_ack, i_stall;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack, d_stall;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TO), .TCW(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    return (a ^ 32'hDEAD_0000) + 32'h11;
  endfunction

  // Memory model: ready in the lat-th cycle of mem_req.
  int lat  = 1;
  bit mute = 1'b0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (mem_req && !mute) begin
      wcnt++;
      mem_ready = (wcnt == lat);
    end else begin
      wcnt = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_word(mem_addr);
  end

  typedef struct {
    bit          side;
    logic [31:0] rd;
    bit          chk;
  } exp_t;
  exp_t sbq[$];

  task automatic push_exp(input bit side, input logic [31:0] rd,
                          input bit chk);
    exp_t e;
    e.side = side;
    e.rd   = rd;
    e.chk  = chk;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (i_ack || d_ack)) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_ack", {i_ack, d_ack}, 0);
      end else begin
        e = sbq.pop_front();
        check("sb_side", d_ack, e.side);
        if (e.chk) check("sb_rdata", d_ack ? d_rdata : i_rdata, e.rd);
      end
    end
  end

  typedef struct {
    bit          side;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    bit          mute;
    int          ecyc;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;

  // Called at a negedge; returns at the negedge after the ack.
  task automatic access(input bit side, input bit we,
                        input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input int l,
                        input bit m, input int ecyc,
                        input logic [31:0] erd);
    int cyc;
    bit got;
    logic [3:0] ebe;
    ebe  = side ? be : 4'hF;
    lat  = l;
    mute = m;
    push_exp(side, erd, !we);
    if (side) begin
      d_req = 1'b1; d_we = we; d_be = be;
      d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    #1 check("stall_c0", side ? d_stall : i_stall, 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      got = side ? d_ack : i_ack;
      if (!got && ecyc > 1) begin
        check("mem_hold", {mem_req, mem_we, mem_be, mem_addr},
              {1'b1, we, ebe, addr});
        if (we) check("mem_wdata", mem_wdata, wd);
        check("stall_busy", side ? d_stall : i_stall, 1);
      end
    end
    if (!got) begin
      check("ack_wait_expired", 0, 1);
    end else begin
      check("latency", cyc, ecyc);
      check("mem_req_ack_cyc", mem_req, 0);
      check("stall_ack_cyc", side ? d_stall : i_stall, 0);
    end
    if (side) d_req = 1'b0;
    else      i_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", side ? d_ack : i_ack, 0);
  endtask

  task automatic wait_ack(input bit side);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side ? d_ack : i_ack) && n < 20);
    if (!(side ? d_ack : i_ack)) check("ack_wait_expired", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 0, 4'hF, 32'h0040_0000, 0, 3, 0, 4,
              32'h8C08_0004, 0};
    vt[1] = '{1, 0, 4'hF, 32'h1001_0000, 0, 1, 0, 2,
              mem_word(32'h1001_0000), 0};
    vt[2] = '{1, 1, 4'b0011, 32'h1001_0004, 32'hAABB_CCDD,
              2, 0, 3, 0, 0};
    vt[3] = '{0, 0, 4'hF, 32'h0040_0004, 0, 1, 0, 2,
              mem_word(32'h0040_0004), 0};
    vt[4] = '{1, 0, 4'hF, 32'h1001_0010, 0, TO, 0, TO + 1,
              mem_word(32'h1001_0010), 0};
    vt[5] = '{1, 0, 4'hF, 32'h1001_0014, 0, 1, 1, TO + 1, 0, 1};
    vt[6] = '{0, 0, 4'hF, 32'h0040_0008, 0, 1, 1, TO + 1, 0, 1};
    vt[7] = '{0, 0, 4'hF, 32'h0040_000C, 0, 2, 0, 3,
              mem_word(32'h0040_000C), 1};

    rst = 1'b1;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctrl", {mem_req, mem_we, i_ack, d_ack, err}, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);

    // Conflict: data first after reset, then instruction.
    lat = 1; mute = 0;
    push_exp(1, mem_word(32'h1001_0000), 1);
    push_exp(0, mem_word(32'h0040_0010), 1);
    push_exp(1, mem_word(32'h1001_0008), 1);
    i_req = 1; i_addr = 32'h0040_0010;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h1001_0000;
    @(negedge clk);
    check("cf_first_data", mem_addr, 32'h1001_0000);
    wait_ack(1);
    d_addr = 32'h1001_0008;
    check("cf_istall", i_stall, 1);
    @(negedge clk);
    check("cf_second_instr", {mem_be, mem_addr},
          {4'hF, 32'h0040_0010});
    wait_ack(0);
    i_req = 0;
    @(negedge clk);
    check("cf_third_data", mem_addr, 32'h1001_0008);
    wait_ack(1);
    d_req = 0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      access(vt[k].side, vt[k].we, vt[k].be, vt[k].addr,
             vt[k].wd, vt[k].lat, vt[k].mute, vt[k].ecyc,
             vt[k].erd);
      check($sformatf("v%0d_err", k), err, vt[k].eerr);
    end

    // Reset in the middle of a data access.
    mute = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h1001_0020;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy", mem_req, 1);
    rst = 1; d_req = 0;
    @(negedge clk);
    check("rst_mid_req_off", mem_req, 0);
    check("rst_mid_no_ack", d_ack, 0);
    check("rst_mid_err_clr", err, 0);
    rst = 0; mute = 0;
    @(negedge clk);
    check("rst_mid_idle", {mem_req, d_ack}, 0);
    access(0, 0, 4'hF, 32'h0040_0020, 0, 1, 0, 2,
           mem_word(32'h0040_0020));

`ifdef MEM_ARB_IBUF_EN
    access(0, 0, 4'hF, 32'h100, 0, 2, 0, 3, mem_word(32'h100));
    access(0, 0, 4'hF, 32'h100, 0, 2, 0, 1, mem_word(32'h100));
    access(1, 1, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 2, 0);
    access(0, 0, 4'hF, 32'h100, 0, 2, 0, 3, mem_word(32'h100));
`else
    access(0, 0, 4'hF, 32'h100, 0, 2, 0, 3, mem_word(32'h100));
    access(0, 0, 4'hF, 32'h100, 0, 2, 0, 3, mem_word(32'h100));
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    check("err_final", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
